fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
Second-generation single-clock synchronous FIFO that replaces the fixed 16x8 FIFO.
- Depth can be any value ≥2, not only powers of two; width is parametrised.
- Almost-full and almost-empty thresholds are programmable; an occupancy count is exported.
- Adds a synchronous flush and a read-valid strobe.
- Sits between producer and consumer stages in the datapath; the existing UVM/SVA environment checks it.

Parameters:
- FIFO_WIDTH, 16, data word width in bits (≥1).
- FIFO_DEPTH, 8, number of entries (≥2, any integer).
- AF_LEVEL, FIFO_DEPTH-1, occupancy at or above which almostfull asserts (1..FIFO_DEPTH-1).
- AE_LEVEL, 1, occupancy at or below which almostempty asserts (1..FIFO_DEPTH-1; must be < AF_LEVEL).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of contents; rst_n has priority
- wr_en  in  1  write request
- data_in  in  FIFO_WIDTH  write data
- rd_en  in  1  read request
- data_out  out  FIFO_WIDTH  registered read data
- rd_valid  out  1  data_out updated this cycle by an accepted read
- wr_ack  out  1  previous-cycle write accepted
- overflow  out  1  previous-cycle write rejected because full
- underflow  out  1  previous-cycle read rejected because empty
- full  out  1  count == FIFO_DEPTH
- empty  out  1  count == 0
- almostfull  out  1  count ≥ AF_LEVEL and not full
- almostempty  out  1  count ≤ AE_LEVEL and not empty
- count  out  CNT_W  occupancy; CNT_W = $clog2(FIFO_DEPTH+1)

Behaviour:
- Reset, sampled on posedge clk when rst_n=0:
  - wr_ptr, rd_ptr, count = 0.
  - data_out = 0.
  - rd_valid, wr_ack, overflow, underflow = 0.
  - Memory contents are not cleared.
- Flags (full, empty, almostfull, almostempty) are combinational from count. With default thresholds they reduce to count==DEPTH-1 and count==1.
- Write accept: wr_en && !full. Memory write at wr_ptr; wr_ptr advances; wr_ack=1 next cycle.
- Write reject: wr_en && full. No state change; overflow=1 next cycle, wr_ack=0.
- Read accept: rd_en && !empty. data_out <= mem[rd_ptr] at the edge (1-cycle latency); rd_ptr advances; rd_valid=1 next cycle.
- Read reject: rd_en && empty. underflow=1 next cycle; data_out holds its value.
- Pulse outputs (wr_ack, overflow, underflow, rd_valid) are single-cycle and are 0 when no request was made.
- Pointer wrap: a pointer equal to FIFO_DEPTH-1 goes to 0 on advance. There is no power-of-two masking.
- Simultaneous wr_en && rd_en:
  - Neither full nor empty: both accepted; count unchanged.
  - Empty: write accepted, read rejected (underflow); count+1.
  - Full: read accepted, write rejected (overflow); count-1.
- Count: +1 on write-only accept, -1 on read-only accept. Never exceeds FIFO_DEPTH and never goes below 0.
- Flush (rst_n=1, flush=1):
  - Pointers and count go to 0; any request in the same cycle is ignored.
  - wr_ack, overflow, underflow, rd_valid = 0; data_out holds.
- Reset mid-operation: takes effect at the next edge regardless of requests. The first request after reset sees an empty FIFO.

Optional Feature:
- Macro FIFO_PEAK_EN.
- Defined:
  - Adds output peak [CNT_W] (high-water mark) and input peak_clr.
  - peak <= max(peak, next count) every cycle.
  - peak <= 0 on reset, flush, or peak_clr (clear wins over update).
- Undefined: the ports and logic do not exist; all other behaviour is identical.

Decomposition:
- Package fifo_pkg holds:
  - function cnt_width(depth) returning $clog2(depth+1);
  - typedef enum for request outcome {ACC, REJ_FULL, REJ_EMPTY, IDLE}, shared with the scoreboard.
- One sub-module, fifo_mem_dp: FIFO_WIDTH x FIFO_DEPTH register array with one synchronous write port and one registered read port.
- Pointer, count and flag logic stay in fifo_sync_param.

Test Plan:
- FIFO_DEPTH=5: write 5 words 0x0001..0x0005 then one more. Expect full=1 and count=5 after the 5th. The 6th gives overflow=1, wr_ack=0, count stays 5.
- FIFO_DEPTH=5, filled as above: read 5. Expect data_out 0x0001..0x0005, each with rd_valid one cycle after rd_en. Then empty=1, and a 6th read gives underflow=1 with data_out holding 0x0005.
- Wrap: DEPTH=5, issue 12 interleaved write/read pairs with data 0xA000+i. Expect in-order output, pointers wrapping 4→0, and count ≤1 throughout.
- Simultaneous requests:
  - Empty, wr_en=rd_en=1: count 0→1, underflow=1, wr_ack=1.
  - Full (5), wr_en=rd_en=1: count 5→4, overflow=1, rd_valid=1.
- Thresholds: AF_LEVEL=3, AE_LEVEL=2, DEPTH=5, fill 0→5. almostempty=1 at count 1,2; almostfull=1 at count 3,4; both 0 at count 0 and 5.
- Flush and reset: with count=3, assert flush. Next cycle count=0, empty=1, and a same-cycle write is ignored. Then with count=2, drop rst_n one cycle: data_out=0 and all pulses are 0. With FIFO_PEAK_EN, peak=3 before the flush and 0 after it.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the parameterised synchronous FIFO.
// Used by the RTL and by the verification scoreboard.
package fifo_pkg;

  // Outcome of a single write or read request in a given cycle
  typedef enum logic [1:0] {
    ACC,
    REJ_FULL,
    REJ_EMPTY,
    IDLE
  } req_outcome_e;

  // Width needed to hold an occupancy of 0..depth inclusive
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Register-array storage for the FIFO: one synchronous write port and one
// registered read port. Storage words are never reset; only the read
// register is, so that data_out comes up as zero.
module fifo_mem_dp #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  // Read register loads the addressed word on an accepted read, else holds
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  // Storage array write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read data register with synchronous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with arbitrary depth (>=2), programmable almost-full /
// almost-empty thresholds, occupancy count, synchronous flush and
// registered read data with a read-valid strobe.
// Optional high-water mark output enabled by defining FIFO_PEAK_EN.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  localparam int CNT_W     = cnt_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
`ifdef FIFO_PEAK_EN
  input  logic                  peak_clr,
  output logic [CNT_W-1:0]      peak,
`endif
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_LEVEL);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ack_q, wr_ack_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             rd_valid_q, rd_valid_d;

  req_outcome_e     wr_outcome;
  req_outcome_e     rd_outcome;
  logic             wr_acc;
  logic             rd_acc;

  // Status flags straight from the occupancy count
  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= AF_C) && !full;
  assign almostempty = (count_q <= AE_C) && !empty;

  // Classify this cycle's requests; flush or reset swallows both
  always_comb begin
    wr_outcome = IDLE;
    rd_outcome = IDLE;
    if (rst_n && !flush) begin
      if (wr_en) wr_outcome = full  ? REJ_FULL  : ACC;
      if (rd_en) rd_outcome = empty ? REJ_EMPTY : ACC;
    end
  end

  assign wr_acc = (wr_outcome == ACC);
  assign rd_acc = (rd_outcome == ACC);

  // Next pointer, count and pulse values from the request outcomes
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wr_ack_d    = (wr_outcome == ACC);
    overflow_d  = (wr_outcome == REJ_FULL);
    rd_valid_d  = (rd_outcome == ACC);
    underflow_d = (rd_outcome == REJ_EMPTY);

    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  fifo_mem_dp #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_q),
    .rd_data (data_out)
  );

  assign count     = count_q;
  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign rd_valid  = rd_valid_q;

`ifdef FIFO_PEAK_EN
  logic [CNT_W-1:0] peak_q, peak_d;

  // High-water mark tracks the upcoming count; any clear source wins
  always_comb begin
    peak_d = (count_d > peak_q) ? count_d : peak_q;
    if (flush || peak_clr) begin
      peak_d = '0;
    end
  end

  // High-water mark register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak = peak_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param (DEPTH=5, AF=3, AE=2).
// Covers the high-water mark output as well when FIFO_PEAK_EN is defined.
module tb_fifo_sync_param;

  localparam int W = 16;
  localparam int D = 5;
  localparam int CW = 3;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          wr_en;
  logic [W-1:0]  data_in;
  logic          rd_en;
  logic [W-1:0]  data_out;
  logic          rd_valid;
  logic          wr_ack;
  logic          overflow;
  logic          underflow;
  logic          full;
  logic          empty;
  logic          almostfull;
  logic          almostempty;
  logic [CW-1:0] count;
`ifdef FIFO_PEAK_EN
  logic          peak_clr;
  logic [CW-1:0] peak;
`endif

  int compared;
  int mismatched;

  fifo_sync_param #(
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (D),
    .AF_LEVEL   (3),
    .AE_LEVEL   (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .rd_valid    (rd_valid),
    .wr_ack      (wr_ack),
    .overflow    (overflow),
    .underflow   (underflow),
    .full        (full),
    .empty       (empty),
    .almostfull  (almostfull),
    .almostempty (almostempty),
`ifdef FIFO_PEAK_EN
    .peak_clr    (peak_clr),
    .peak        (peak),
`endif
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of requests, then settle just past the edge
  task automatic applyStimulus(input logic wr, input logic [W-1:0] din,
                               input logic rd, input logic fl);
    wr_en   = wr;
    data_in = din;
    rd_en   = rd;
    flush   = fl;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkPulses(input string tag, input logic ack, input logic ovf,
                             input logic unf, input logic vld);
    checkOutput({tag, ".wr_ack"},    32'(wr_ack),    32'(ack));
    checkOutput({tag, ".overflow"},  32'(overflow),  32'(ovf));
    checkOutput({tag, ".underflow"}, 32'(underflow), 32'(unf));
    checkOutput({tag, ".rd_valid"},  32'(rd_valid),  32'(vld));
  endtask

  task automatic checkFlags(input string tag, input int cnt);
    checkOutput({tag, ".count"},       32'(count),       32'(cnt));
    checkOutput({tag, ".full"},        32'(full),        32'(cnt == 5));
    checkOutput({tag, ".empty"},       32'(empty),       32'(cnt == 0));
    checkOutput({tag, ".almostfull"},  32'(almostfull),  32'(cnt == 3 || cnt == 4));
    checkOutput({tag, ".almostempty"}, 32'(almostempty), 32'(cnt == 1 || cnt == 2));
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n   = 1'b0;
    flush   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
`ifdef FIFO_PEAK_EN
    peak_clr = 1'b0;
`endif

    // Reset state
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h1234, 1'b1, 1'b0);
    checkFlags("reset", 0);
    checkPulses("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.data_out", 32'(data_out), 32'h0);
`ifdef FIFO_PEAK_EN
    checkOutput("reset.peak", 32'(peak), 32'h0);
`endif
    rst_n = 1'b1;

    // Fill 0x0001..0x0005; thresholds checked at every level
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 16'(i), 1'b0, 1'b0);
      checkPulses($sformatf("fill%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
      checkFlags($sformatf("fill%0d", i), i);
    end
    applyStimulus(1'b1, 16'h0006, 1'b0, 1'b0);
    checkPulses("ovf", 1'b0, 1'b1, 1'b0, 1'b0);
    checkFlags("ovf", 5);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    checkPulses("idle", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FIFO_PEAK_EN
    checkOutput("peak.full", 32'(peak), 32'd5);
`endif

    // Drain in order, then underflow holds the last word
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkPulses($sformatf("drain%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("drain%0d.data", i), 32'(data_out), 32'(i));
      checkFlags($sformatf("drain%0d", i), 5 - i);
    end
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkPulses("unf", 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("unf.data", 32'(data_out), 32'h0005);
    checkOutput("unf.count", 32'(count), 32'h0);

    // Twelve write/read pairs wrap both pointers several times
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0);
      checkOutput($sformatf("wrap%0d.wcount", i), 32'(count), 32'd1);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput($sformatf("wrap%0d.data", i), 32'(data_out), 32'hA000 + 32'(i));
      checkOutput($sformatf("wrap%0d.rcount", i), 32'(count), 32'd0);
      checkOutput($sformatf("wrap%0d.vld", i), 32'(rd_valid), 32'd1);
    end

    // Simultaneous requests while empty: write wins, read underflows
    applyStimulus(1'b1, 16'h0B0B, 1'b1, 1'b0);
    checkPulses("simE", 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("simE.count", 32'(count), 32'd1);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 16'h0C00 + 16'(i), 1'b0, 1'b0);
    checkFlags("prefull", 5);

    // Simultaneous requests while full: read wins, write overflows
    applyStimulus(1'b1, 16'h0DDD, 1'b1, 1'b0);
    checkPulses("simF", 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("simF.count", 32'(count), 32'd4);
    checkOutput("simF.data", 32'(data_out), 32'h0B0B);

    // Simultaneous requests mid-range: both accepted, count steady
    applyStimulus(1'b1, 16'h0E0E, 1'b1, 1'b0);
    checkPulses("simM", 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("simM.count", 32'(count), 32'd4);
    checkOutput("simM.data", 32'(data_out), 32'h0C01);

    // Bring count to 3 and restart the high-water mark there
`ifdef FIFO_PEAK_EN
    peak_clr = 1'b1;
`endif
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
`ifdef FIFO_PEAK_EN
    peak_clr = 1'b0;
    checkOutput("peak.clr", 32'(peak), 32'd0);
`endif
    checkOutput("pre.data", 32'(data_out), 32'h0C02);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    checkFlags("preflush", 3);
`ifdef FIFO_PEAK_EN
    checkOutput("peak.pre", 32'(peak), 32'd3);
`endif

    // Flush with a same-cycle write: write ignored, data_out holds
    applyStimulus(1'b1, 16'h0F0F, 1'b0, 1'b1);
    checkFlags("flush", 0);
    checkPulses("flush", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("flush.data", 32'(data_out), 32'h0C02);
`ifdef FIFO_PEAK_EN
    checkOutput("peak.flush", 32'(peak), 32'd0);
`endif
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkPulses("postflush", 1'b0, 1'b0, 1'b1, 1'b0);

    // Count 2 with non-zero data_out, then reset during requests
    applyStimulus(1'b1, 16'h1111, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h2222, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h3333, 1'b1, 1'b0);
    checkOutput("prerst.data", 32'(data_out), 32'h1111);
    checkOutput("prerst.count", 32'(count), 32'd2);
    rst_n = 1'b0;
    applyStimulus(1'b1, 16'h5555, 1'b1, 1'b0);
    rst_n = 1'b1;
    checkFlags("midrst", 0);
    checkPulses("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst.data", 32'(data_out), 32'h0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkPulses("postrst", 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h4444, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("postrst.data", 32'(data_out), 32'h4444);
    checkFlags("postrst", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
